// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: EX-side request and HI/LO write stream of the multiply/divide unit
//   master: start, op, operand_a, operand_b, flush out; stall_req, hilo_write_en, hi/lo_write_data in
//   slave : the mirror image, used by hilo_muldiv_unit
interface hilo_muldiv_if #(parameter int DATA_WIDTH = 32);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  flush;
    logic                  stall_req;
    logic                  hilo_write_en;
    logic [DATA_WIDTH-1:0] hi_write_data;
    logic [DATA_WIDTH-1:0] lo_write_data;
    modport master(output start, op, operand_a, operand_b, flush,
                   input stall_req, hilo_write_en, hi_write_data, lo_write_data);
    modport slave(input start, op, operand_a, operand_b, flush,
                  output stall_req, hilo_write_en, hi_write_data, lo_write_data);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine emitting one HI/LO write per operation
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hilo_muldiv_if (request in, stall and HI/LO write out)
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_CYCLES = 32
) (
    input logic         clk,
    input logic         rst_n,
    hilo_muldiv_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DIV_CYCLES);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;
    state_t state, next;
    logic [W-1:0]  a_q, b_q, quo, rem, bm, hi_q, lo_q, new_rem, new_quo, a_mag, b_mag;
    logic [CW-1:0] cnt;
    logic          uns_q, neg_q, neg_r, go, sgn, div0, last, ge;
    logic [W:0]    trial;
    logic [2*W-1:0] prod;
    assign go    = state == IDLE && bus.start && !bus.flush;
    assign sgn   = !bus.op[0];
    assign div0  = bus.operand_b == '0;
    assign last  = cnt == CW'(DIV_CYCLES - 1);
    assign a_mag = (sgn && bus.operand_a[W-1]) ? -bus.operand_a : bus.operand_a;
    assign b_mag = (sgn && bus.operand_b[W-1]) ? -bus.operand_b : bus.operand_b;
    // sign-extending both factors to 2W makes one unsigned multiplier serve both MULT and MULTU
    assign prod  = {{W{!uns_q && a_q[W-1]}}, a_q} * {{W{!uns_q && b_q[W-1]}}, b_q};
    // restoring step: shift the next dividend bit into the partial remainder and try to subtract
    assign trial   = {rem, quo[W-1]} - {1'b0, bm};
    assign ge      = !trial[W];
    assign new_rem = ge ? trial[W-1:0] : {rem[W-2:0], quo[W-1]};
    assign new_quo = {quo[W-2:0], ge};
    assign bus.stall_req     = go || state == MUL || state == DIV;
    assign bus.hilo_write_en = state == FINISH;
    assign bus.hi_write_data = hi_q;
    assign bus.lo_write_data = lo_q;
    always_comb begin
        next = state;
        if (bus.flush) next = IDLE;
        else case (state)
            IDLE:    next = !bus.start ? IDLE : !bus.op[1] ? MUL : div0 ? FINISH : DIV;
            MUL:     next = FINISH;
            DIV:     next = last ? FINISH : DIV;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a_q, b_q, quo, rem, bm, hi_q, lo_q} <= '0;
            {cnt, uns_q, neg_q, neg_r}          <= '0;
        end else if (go) begin
            a_q   <= bus.operand_a;
            b_q   <= bus.operand_b;
            uns_q <= bus.op[0];
            quo   <= a_mag;
            bm    <= b_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sgn && (bus.operand_a[W-1] ^ bus.operand_b[W-1]);
            neg_r <= sgn && bus.operand_a[W-1];
            if (bus.op[1] && div0) begin
                hi_q <= bus.operand_a;
                lo_q <= '1;
            end
        end else if (state == MUL && !bus.flush) begin
            {hi_q, lo_q} <= prod;
        end else if (state == DIV) begin
            rem <= new_rem;
            quo <= new_quo;
            cnt <= cnt + 1'b1;
            if (last && !bus.flush) begin
                hi_q <= neg_r ? -new_rem : new_rem;
                lo_q <= neg_q ? -new_quo : new_quo;
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    logic clk = 0;
    logic rst_n = 0;
    int total = 0;
    int bad = 0;
    hilo_muldiv_if #(.DATA_WIDTH(32)) bus();
    hilo_muldiv_unit #(.DATA_WIDTH(32), .DIV_CYCLES(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // issues one operation and measures latency to the write strobe; stall_ok requires
    // stall_req high in every cycle before the write and low in the write cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit stall_ok, output logic [31:0] hi, output logic [31:0] lo);
        lat = -1; stall_ok = 1; hi = 'x; lo = 'x;
        @(negedge clk);
        bus.start = 1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.hilo_write_en) begin
                lat = c; hi = bus.hi_write_data; lo = bus.lo_write_data;
                if (bus.stall_req) stall_ok = 0;
                break;
            end
            if (!bus.stall_req) stall_ok = 0;
            @(negedge clk);
            bus.start = 0; bus.op = ~o; bus.operand_a = 32'hDEADBEEF; bus.operand_b = 32'h0BAD0BAD;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall_req); end
        total++; if (bus.hilo_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.hilo_write_en); end
        total++; if (bus.hi_write_data !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi_write_data); end
        total++; if (bus.lo_write_data !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo_write_data); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int elat, input logic [31:0] ehi, input logic [31:0] elo);
        int lat; bit ok; logic [31:0] hi, lo;
        run_op(o, a, b, lat, ok, hi, lo);
        total++; if (lat != elat) begin bad++; $display("FAIL %s_lat got=%0d want=%0d", name, lat, elat); end
        total++; if (!ok) begin bad++; $display("FAIL %s_stall got=bad_pattern want=high_until_write", name); end
        total++; if (hi !== ehi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, hi, ehi); end
        total++; if (lo !== elo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, lo, elo); end
    endtask

    task automatic test_mult();
        check_op("mult", 2'b00, 32'hFFFFFFFF, 32'd2, 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        check_op("multu", 2'b01, 32'hFFFFFFFF, 32'd2, 2, 32'h00000001, 32'hFFFFFFFE);
        check_op("mult_neg_neg", 2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 2, 32'h0, 32'd15);
    endtask

    task automatic test_div();
        check_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
        check_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        check_op("divu_big", 2'b11, 32'hFFFFFFF9, 32'd2, 33, 32'd1, 32'h7FFFFFFC);
        check_op("div_wrap", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    endtask

    task automatic test_div_zero();
        check_op("divu_zero", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);
        check_op("div_zero", 2'b10, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF);
    endtask

    task automatic test_flush();
        logic [31:0] ph, pl;
        bit seen;
        ph = bus.hi_write_data; pl = bus.lo_write_data;
        @(negedge clk); bus.start = 1; bus.op = 2'b10; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
        @(negedge clk); bus.start = 0;
        repeat (9) @(negedge clk);
        bus.flush = 1; #1;
        total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL flush_t10_stall got=%b want=1", bus.stall_req); end
        @(negedge clk); bus.flush = 0; #1;
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL flush_t11_stall got=%b want=0", bus.stall_req); end
        seen = 0;
        repeat (40) begin @(negedge clk); #1; if (bus.hilo_write_en) seen = 1; end
        total++; if (seen) begin bad++; $display("FAIL flush_no_write got=write want=none"); end
        total++; if (bus.hi_write_data !== ph || bus.lo_write_data !== pl)
            begin bad++; $display("FAIL flush_hold got=%h_%h want=%h_%h", bus.hi_write_data, bus.lo_write_data, ph, pl); end
        @(negedge clk); bus.start = 1; bus.flush = 1; bus.op = 2'b11; bus.operand_a = 32'd9; bus.operand_b = 32'd0; #1;
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL start_flush_stall got=%b want=0", bus.stall_req); end
        @(negedge clk); bus.start = 0; bus.flush = 0;
        seen = 0;
        repeat (5) begin #1; if (bus.hilo_write_en || bus.stall_req) seen = 1; @(negedge clk); end
        total++; if (seen) begin bad++; $display("FAIL start_flush_latched got=activity want=idle"); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk); bus.start = 1; bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
        @(negedge clk); bus.start = 0;
        repeat (4) @(negedge clk);
        rst_n = 0; #1;
        total++; if (bus.stall_req !== 1'b0 || bus.hilo_write_en !== 1'b0)
            begin bad++; $display("FAIL rst_mid_ctrl got=%b%b want=00", bus.stall_req, bus.hilo_write_en); end
        total++; if (bus.hi_write_data !== 32'h0 || bus.lo_write_data !== 32'h0)
            begin bad++; $display("FAIL rst_mid_data got=%h_%h want=0_0", bus.hi_write_data, bus.lo_write_data); end
        @(negedge clk); rst_n = 1;
        seen = 0;
        repeat (40) begin @(negedge clk); #1; if (bus.hilo_write_en) seen = 1; end
        total++; if (seen) begin bad++; $display("FAIL rst_mid_no_write got=write want=none"); end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_divu", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        check_op("b2b_multu", 2'b01, 32'h00010000, 32'h00010000, 2, 32'h1, 32'h0);
        check_op("b2b_mult", 2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 2, 32'h3FFFFFFF, 32'h00000001);
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
